// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Merges pipeline write-backs and queued mul/div results onto the
//            single register-file write port; tracks pending mul/div dests.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_addr,
  input  logic [DATA_W-1:0]        pipe_data,
  input  logic                     md_valid,
  input  logic [4:0]               md_addr,
  input  logic [DATA_W-1:0]        md_data,
  output logic                     md_ready,
  output logic [$clog2(DEPTH):0]   md_count,
  input  logic                     issue_valid,
  input  logic [4:0]               issue_addr,
  input  logic [4:0]               rd_addr1,
  input  logic [4:0]               rd_addr2,
  output logic                     busy1,
  output logic                     busy2,
  output logic                     RegWrite,
  output logic [4:0]               Wreg_addr,
  output logic [DATA_W-1:0]        Wdata
);

  localparam int              c_aw   = $clog2(DEPTH);
  localparam logic [c_aw:0]   c_full = (c_aw + 1)'(DEPTH);

  logic [4:0]        r_fifo_addr [DEPTH];
  logic [DATA_W-1:0] r_fifo_data [DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic [31:0]       r_pending;

  logic              w_pipe;
  logic              w_push;
  logic              w_pop;
  logic [4:0]        w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [31:0]       w_pending_nxt;

  // Readiness looks only at registered occupancy, so a pop never frees a slot
  // for a push on the same edge.
  assign md_ready = (r_count < c_full);
  assign md_count = r_count;

  always_comb begin
    w_pipe      = pipe_we && (pipe_addr != 5'd0);
    w_push      = md_valid && md_ready && (md_addr != 5'd0);
    w_pop       = !w_pipe && (r_count != '0);
    w_head_addr = r_fifo_addr[r_rd_ptr];
    w_head_data = r_fifo_data[r_rd_ptr];
  end

  // Clear-then-set ordering makes an issue win over a same-edge pop.
  always_comb begin
    w_pending_nxt = r_pending;
    if (w_pop) begin
      w_pending_nxt[w_head_addr] = 1'b0;
    end
    if (issue_valid && (issue_addr != 5'd0)) begin
      w_pending_nxt[issue_addr] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  assign busy1 = (rd_addr1 != 5'd0) && r_pending[rd_addr1];
  assign busy2 = (rd_addr2 != 5'd0) && r_pending[rd_addr2];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= md_addr;
      r_fifo_data[r_wr_ptr] <= md_data;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Write-port holds address/data when idle; only RegWrite drops.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      RegWrite  <= 1'b0;
      Wreg_addr <= 5'd0;
      Wdata     <= '0;
    end else begin
      RegWrite <= w_pipe || w_pop;
      if (w_pipe) begin
        Wreg_addr <= pipe_addr;
        Wdata     <= pipe_data;
      end else if (w_pop) begin
        Wreg_addr <= w_head_addr;
        Wdata     <= w_head_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Directed self-checking bench for regfile_writeback.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;

  logic              CLK;
  logic              RST_N;
  logic              pipe_we;
  logic [4:0]        pipe_addr;
  logic [DATA_W-1:0] pipe_data;
  logic              md_valid;
  logic [4:0]        md_addr;
  logic [DATA_W-1:0] md_data;
  logic              md_ready;
  logic [2:0]        md_count;
  logic              issue_valid;
  logic [4:0]        issue_addr;
  logic [4:0]        rd_addr1;
  logic [4:0]        rd_addr2;
  logic              busy1;
  logic              busy2;
  logic              RegWrite;
  logic [4:0]        Wreg_addr;
  logic [DATA_W-1:0] Wdata;

  int n_assert = 0;
  int n_fail   = 0;

  regfile_writeback #(.DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .md_valid(md_valid), .md_addr(md_addr), .md_data(md_data),
    .md_ready(md_ready), .md_count(md_count),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .busy1(busy1), .busy2(busy2),
    .RegWrite(RegWrite), .Wreg_addr(Wreg_addr), .Wdata(Wdata)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST_N = 1'b0; pipe_we = 1'b0; pipe_addr = '0; pipe_data = '0;
    md_valid = 1'b0; md_addr = '0; md_data = '0;
    issue_valid = 1'b0; issue_addr = '0; rd_addr1 = 5'd9; rd_addr2 = 5'd5;

    // Reset state
    tick(); tick();
    chk("rst_regwrite", RegWrite, 1'b0);
    chk("rst_waddr", Wreg_addr, 5'd0);
    chk("rst_wdata", Wdata, 32'd0);
    chk("rst_ready", md_ready, 1'b1);
    chk("rst_count", md_count, 3'd0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_busy2", busy2, 1'b0);
    @(negedge CLK); RST_N = 1'b1;
    tick();
    chk("idle_regwrite", RegWrite, 1'b0);

    // Pipeline write r8 then r0
    pipe_we = 1'b1; pipe_addr = 5'd8; pipe_data = 32'h0000_00AA;
    tick();
    chk("pipe_regwrite", RegWrite, 1'b1);
    chk("pipe_waddr", Wreg_addr, 5'd8);
    chk("pipe_wdata", Wdata, 32'hAA);
    pipe_we = 1'b0;
    tick();
    chk("pipe_oneshot", RegWrite, 1'b0);
    chk("pipe_hold_addr", Wreg_addr, 5'd8);
    chk("pipe_hold_data", Wdata, 32'hAA);
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = 32'h55;
    tick();
    chk("pipe_r0_regwrite", RegWrite, 1'b0);
    chk("pipe_r0_data", Wdata, 32'hAA);
    pipe_we = 1'b0;

    // Issue r9, then mul/div result r9
    issue_valid = 1'b1; issue_addr = 5'd9;
    tick();
    issue_valid = 1'b0;
    chk("iss_busy1_set", busy1, 1'b1);
    chk("iss_ready", md_ready, 1'b1);
    md_valid = 1'b1; md_addr = 5'd9; md_data = 32'h1234;
    tick();
    md_valid = 1'b0;
    chk("md_count1", md_count, 3'd1);
    chk("md_busy_still", busy1, 1'b1);
    chk("md_no_bypass", RegWrite, 1'b0);
    tick();
    chk("md_regwrite", RegWrite, 1'b1);
    chk("md_waddr", Wreg_addr, 5'd9);
    chk("md_wdata", Wdata, 32'h1234);
    chk("md_busy_clr", busy1, 1'b0);
    chk("md_count0", md_count, 3'd0);
    tick();
    chk("md_regwrite_off", RegWrite, 1'b0);

    // Back-pressure: 6 pipe writes while 5 results offered
    begin
      int j;
      j = 0;
      md_valid = 1'b1;
      for (int k = 0; k < 6; k++) begin
        pipe_we = 1'b1; pipe_addr = 5'(10 + k); pipe_data = 32'h100 + k;
        md_addr = 5'(16 + j); md_data = 32'h200 + j;
        chk("bp_ready", md_ready, (k < 4) ? 1'b1 : 1'b0);
        if (k < 4) j++;
        tick();
        chk("bp_pipe_regwrite", RegWrite, 1'b1);
        chk("bp_pipe_waddr", Wreg_addr, 5'(10 + k));
        chk("bp_count", md_count, (k < 4) ? 3'(k + 1) : 3'd4);
      end
      pipe_we = 1'b0;
      md_addr = 5'd20; md_data = 32'h204;
      chk("bp_full_ready", md_ready, 1'b0);
      tick();  // full: pop only
      chk("bp_pop0_addr", Wreg_addr, 5'd16);
      chk("bp_pop0_data", Wdata, 32'h200);
      chk("bp_pop0_count", md_count, 3'd3);
      chk("bp_ready_again", md_ready, 1'b1);
      tick();  // push 5th, pop 2nd
      md_valid = 1'b0;
      chk("bp_pop1_data", Wdata, 32'h201);
      chk("bp_pop1_count", md_count, 3'd3);
      tick();
      chk("bp_pop2_data", Wdata, 32'h202);
      tick();
      chk("bp_pop3_data", Wdata, 32'h203);
      chk("bp_pop3_count", md_count, 3'd1);
      tick();
      chk("bp_pop4_addr", Wreg_addr, 5'd20);
      chk("bp_pop4_data", Wdata, 32'h204);
      chk("bp_pop4_regwrite", RegWrite, 1'b1);
      chk("bp_empty", md_count, 3'd0);
      tick();
      chk("bp_idle", RegWrite, 1'b0);
    end

    // Steady push+pop at occupancy 2 with pointer wrap
    pipe_we = 1'b1; pipe_addr = 5'd31; pipe_data = 32'h31;
    md_valid = 1'b1;
    md_addr = 5'd1; md_data = 32'h300; tick();
    md_addr = 5'd2; md_data = 32'h301; tick();
    chk("wrap_fill", md_count, 3'd2);
    pipe_we = 1'b0;
    for (int c = 0; c < 10; c++) begin
      md_addr = 5'(1 + ((c + 2) % 8)); md_data = 32'h300 + 32'(c + 2);
      tick();
      chk("wrap_count", md_count, 3'd2);
      chk("wrap_addr", Wreg_addr, 5'(1 + (c % 8)));
      chk("wrap_data", Wdata, 32'h300 + 32'(c));
    end
    md_valid = 1'b0;
    tick();
    chk("wrap_tail0", Wdata, 32'h30A);
    tick();
    chk("wrap_tail1", Wdata, 32'h30B);
    chk("wrap_empty", md_count, 3'd0);

    // Issue and pop of r5 on same edge: set wins
    chk("sb_busy2_clear", busy2, 1'b0);
    issue_valid = 1'b1; issue_addr = 5'd5;
    tick();
    issue_valid = 1'b0;
    chk("sb_busy2_set", busy2, 1'b1);
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'h555;
    tick();
    md_valid = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd5;
    tick();
    issue_valid = 1'b0;
    chk("sb_pop_r5", Wreg_addr, 5'd5);
    chk("sb_set_wins", busy2, 1'b1);
    md_valid = 1'b1; md_addr = 5'd5; md_data = 32'h556;
    tick();
    md_valid = 1'b0;
    tick();
    chk("sb_pop2_data", Wdata, 32'h556);
    chk("sb_busy2_final", busy2, 1'b0);

    // md_addr=0: handshake only
    md_valid = 1'b1; md_addr = 5'd0; md_data = 32'hDEAD;
    chk("r0_ready", md_ready, 1'b1);
    tick();
    md_valid = 1'b0;
    chk("r0_count", md_count, 3'd0);
    tick();
    chk("r0_no_pop", RegWrite, 1'b0);

    // Asynchronous reset with three entries queued
    issue_valid = 1'b1; issue_addr = 5'd12; rd_addr1 = 5'd12;
    tick();
    issue_valid = 1'b0;
    pipe_we = 1'b1; pipe_addr = 5'd2; pipe_data = 32'h2;
    md_valid = 1'b1;
    md_addr = 5'd12; md_data = 32'hC; tick();
    md_addr = 5'd13; md_data = 32'hD; tick();
    md_addr = 5'd14; md_data = 32'hE; tick();
    pipe_we = 1'b0; md_valid = 1'b0;
    chk("ar_count3", md_count, 3'd3);
    chk("ar_busy_pre", busy1, 1'b1);
    #1 RST_N = 1'b0;
    #1;
    chk("ar_count", md_count, 3'd0);
    chk("ar_ready", md_ready, 1'b1);
    chk("ar_busy1", busy1, 1'b0);
    chk("ar_regwrite", RegWrite, 1'b0);
    chk("ar_wdata", Wdata, 32'd0);
    tick();
    @(negedge CLK); RST_N = 1'b1;
    tick();
    chk("ar_post_count", md_count, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
